// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and sizing helpers for seq_alu.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic op_legal(input logic [3:0] op, input logic mul_en);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: return 1'b1;
      OP_MUL:                                        return mul_en;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU slice: optional operand inversion, AND/OR/ADD/Less select.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] a_p, b_p;
  logic [WIDTH:0]   sum;
  logic             less;

  always_comb begin
    a_p    = op_i[3] ? ~a_i : a_i;
    b_p    = op_i[2] ? ~b_i : b_i;
    sum    = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, op_i[2]};
    cout_o = sum[WIDTH];
    ovf_o  = (a_p[WIDTH-1] == b_p[WIDTH-1]) && (sum[WIDTH-1] != a_p[WIDTH-1]);
    // Sign of the true difference: sum MSB corrected by overflow.
    less   = sum[WIDTH-1] ^ ovf_o;
    case (op_i[1:0])
      2'b00:   result_o = a_p & b_p;
      2'b01:   result_o = a_p | b_p;
      2'b10:   result_o = sum[WIDTH-1:0];
      default: result_o = {{(WIDTH-1){1'b0}}, less};
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops and an iterative shift-add multiply
// that reuses the alu_core adder for partial-sum accumulation.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 24,
  parameter int MUL_EN = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             COUT,
  output logic             OVF,
  output logic             ILLEGAL,
  output logic             BUSY,
  output logic             DONE
);

  localparam int   CNT_W   = cnt_width(WIDTH);
  localparam logic MUL_ON  = (MUL_EN != 0);

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, hi_q;
  logic [3:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, cout_q, ovf_q, illegal_q, busy_q, done_q;

  logic [WIDTH-1:0] core_a, core_b, core_res;
  logic [3:0]       core_op;
  logic             core_cout, core_ovf;

  logic [WIDTH-1:0] result_d;
  logic             zero_d, cout_d, ovf_d, illegal_d;

  // In MUL the core accumulates the multiplicand into the high product half
  // whenever the current multiplier LSB (b_q[0]) is set.
  always_comb begin
    core_a  = a_q;
    core_b  = b_q;
    core_op = op_q;
    if (state_q == MUL) begin
      core_a  = hi_q;
      core_b  = b_q[0] ? a_q : '0;
      core_op = OP_ADD;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (core_a),
    .b_i      (core_b),
    .op_i     (core_op),
    .result_o (core_res),
    .cout_o   (core_cout),
    .ovf_o    (core_ovf)
  );

  always_comb begin
    result_d  = '0;
    cout_d    = 1'b0;
    ovf_d     = 1'b0;
    illegal_d = 1'b0;
    if (!op_legal(op_q, MUL_ON)) begin
      illegal_d = 1'b1;
    end else if (MUL_ON && op_q == OP_MUL) begin
      result_d = b_q;
      ovf_d    = |hi_q;
    end else begin
      result_d = core_res;
      cout_d   = op_q[1] & core_cout;
      ovf_d    = op_q[1] & core_ovf;
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (START) begin
            a_q     <= A;
            b_q     <= B;
            op_q    <= OP;
            hi_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (MUL_ON && OP == OP_MUL) ? MUL : FIN;
          end
        end
        MUL: begin
          // {hi,lo} <= ({carry,sum,lo}) >> 1; b_q doubles as the low product half.
          hi_q  <= {core_cout, core_res[WIDTH-1:1]};
          b_q   <= {core_res[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIN;
        end
        FIN: begin
          result_q  <= result_d;
          zero_q    <= zero_d;
          cout_q    <= cout_d;
          ovf_q     <= ovf_d;
          illegal_q <= illegal_d;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign RESULT  = result_q;
  assign ZERO    = zero_q;
  assign COUT    = cout_q;
  assign OVF     = ovf_q;
  assign ILLEGAL = illegal_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases plus random ops against an arithmetic model.
module tb_seq_alu;

  localparam int W = 24;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         START;
  logic [3:0]   OP;
  logic [W-1:0] A, B;
  logic [W-1:0] RESULT;
  logic         ZERO, COUT, OVF, ILLEGAL, BUSY, DONE;

  int n_tests = 0;
  int n_fail  = 0;

  seq_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .START   (START),
    .OP      (OP),
    .A       (A),
    .B       (B),
    .RESULT  (RESULT),
    .ZERO    (ZERO),
    .COUT    (COUT),
    .OVF     (OVF),
    .ILLEGAL (ILLEGAL),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic z, output logic c,
                                output logic o, output logic il);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint unsigned p;
    longint sa, sb, d;
    longint maxs = (longint'(1) <<< (W - 1)) - 1;
    longint mins = -(longint'(1) <<< (W - 1));
    sa = a[W-1] ? longint'(ua) - (longint'(1) <<< W) : longint'(ua);
    sb = b[W-1] ? longint'(ub) - (longint'(1) <<< W) : longint'(ub);
    r = '0; c = 1'b0; o = 1'b0; il = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1100: r = ~(a | b);
      4'b0010: begin
        p = ua + ub; r = p[W-1:0]; c = p[W];
        d = sa + sb; o = (d > maxs) || (d < mins);
      end
      4'b0110: begin
        r = a - b; c = (ua >= ub);
        d = sa - sb; o = (d > maxs) || (d < mins);
      end
      4'b0111: begin
        r = {{(W-1){1'b0}}, (sa < sb)}; c = (ua >= ub);
        d = sa - sb; o = (d > maxs) || (d < mins);
      end
      4'b1011: begin
        p = ua * ub; r = p[W-1:0]; o = ((p >> W) != 0);
      end
      default: il = 1'b1;
    endcase
    z = (r == '0);
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic ez, ec, eo, eil;
    int cyc, lat;
    logic got;
    model(op, a, b, er, ez, ec, eo, eil);
    lat = (op == 4'b1011) ? W + 1 : 1;
    @(negedge CLK);
    START = 1'b1; OP = op; A = a; B = b;
    @(posedge CLK); #1;
    START = 1'b0; OP = 4'($urandom); A = W'($urandom); B = W'($urandom);
    chk("busy_after_accept", 64'(BUSY), 64'(1));
    cyc = 0; got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge CLK); #1;
      cyc++;
      if (DONE) got = 1'b1;
    end
    chk($sformatf("latency op=%b", op), 64'(cyc), 64'(lat));
    chk($sformatf("result op=%b a=%h b=%h", op, a, b), 64'(RESULT), 64'(er));
    chk($sformatf("flags op=%b a=%h b=%h", op, a, b),
        64'({ZERO, COUT, OVF, ILLEGAL}), 64'({ez, ec, eo, eil}));
  endtask

  logic [3:0] legal_ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1011};

  initial begin
    int dones, dcyc;
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;

    RSTn = 1'b0; START = 1'b0; OP = '0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outputs", 64'({RESULT, ZERO, COUT, OVF, ILLEGAL, BUSY, DONE}), 64'(0));
    @(negedge CLK); RSTn = 1'b1;

    run_op(4'b0010, 24'h7FFFFF, 24'h000001);
    chk("add_ovf_const", 64'({RESULT, OVF, COUT}), 64'({24'h800000, 1'b1, 1'b0}));

    run_op(4'b0110, 24'd5, 24'd5);
    chk("sub_eq_const", 64'({RESULT, ZERO, COUT}), 64'({24'h000000, 1'b1, 1'b1}));

    run_op(4'b0111, 24'hFFFFFF, 24'h000001);
    chk("slt_neg_const", 64'(RESULT), 64'(24'h000001));

    // Product 0x3000000 lies entirely above bit 23.
    run_op(4'b1011, 24'h001000, 24'h003000);
    chk("mul_wrap_const", 64'({RESULT, OVF, ZERO}), 64'({24'h000000, 1'b1, 1'b1}));

    run_op(4'b1011, 24'd123, 24'd456);
    chk("mul_small_const", 64'({RESULT, OVF}), 64'({24'h00DB18, 1'b0}));

    run_op(4'b1011, 24'hABCDEF, 24'h000000);

    run_op(4'b0101, 24'h123456, 24'h654321);
    chk("illegal_const", 64'({RESULT, ZERO, ILLEGAL}), 64'({24'h000000, 1'b1, 1'b1}));
    run_op(4'b0000, 24'hF0F0F0, 24'hFF00FF);
    chk("legal_clears_illegal", 64'(ILLEGAL), 64'(0));

    // START held during an in-flight MUL with changing operands.
    @(negedge CLK);
    START = 1'b1; OP = 4'b1011; A = 24'd123; B = 24'd456;
    @(posedge CLK); #1;
    dones = 0; dcyc = 0;
    for (int i = 1; i <= W + 1; i++) begin
      @(negedge CLK);
      START = 1'b1; OP = 4'($urandom); A = W'($urandom); B = W'($urandom);
      @(posedge CLK); #1;
      if (DONE) begin dones++; dcyc = i; end
    end
    START = 1'b0;
    chk("busy_start_done_count", 64'(dones), 64'(1));
    chk("busy_start_done_cycle", 64'(dcyc), 64'(W + 1));
    chk("busy_start_result", 64'(RESULT), 64'(24'h00DB18));
    @(posedge CLK); #1;
    chk("fin_start_not_queued", 64'({BUSY, DONE}), 64'(0));

    // Reset in the middle of a MUL.
    @(negedge CLK);
    START = 1'b1; OP = 4'b1011; A = 24'h000777; B = 24'h000999;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLK);
    #2;
    RSTn = 1'b0;
    #1;
    chk("midmul_reset_outputs", 64'({RESULT, ZERO, COUT, OVF, ILLEGAL, BUSY, DONE}), 64'(0));
    dones = 0;
    repeat (2) begin @(posedge CLK); #1; if (DONE) dones++; end
    @(negedge CLK); RSTn = 1'b1;
    repeat (30) begin @(posedge CLK); #1; if (DONE) dones++; end
    chk("midmul_no_done", 64'(dones), 64'(0));
    run_op(4'b0010, 24'd2, 24'd3);
    chk("post_reset_add", 64'(RESULT), 64'(24'd5));

    for (int i = 0; i < 30; i++) begin
      rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_ops[$urandom_range(0, 6)];
      ra  = W'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? ra : W'($urandom);
      run_op(rop, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
